uart_rx_fifo: RTL and testbench

Receive-side word buffer that sits directly downstream of the UART receiver and upstream of the command decoder.
- Captures each 9-bit word on the receiver's one-cycle done pulse.
- Presents words in order over a first-word-fall-through valid/ready interface.
- Tracks overflow and framing-error events for status reporting.
- Decouples byte arrival at 9600 baud from consumer back-pressure.

---
 rtl/uart_rx_fifo.sv | 106 ++++++++++
 tb/tb_uart_rx_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive word buffer between the UART receiver and the command decoder: first-word-fall-through
// queue with overflow and framing-error status. UART_RX_FIFO_ALMOST_FULL_EN adds almost_full/high_water.
module uart_rx_fifo #(
  parameter int DEPTH        = 8,
  parameter int WIDTH        = 9,
  parameter int AFULL_THRESH = 6
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           rx_data,
  input  logic                       rx_done,
  input  logic                       rx_framing_error,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 frame_err_cnt,
  input  logic                       clear_status
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     high_water
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             fe_prev;
  logic             push;
  logic             pop;
  logic             ovf_evt;
  logic             fe_evt;

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // A full queue still accepts a word when the head leaves in the same cycle.
  assign pop     = out_valid & out_ready;
  assign push    = rx_done & ((count < FULL) | pop);
  assign ovf_evt = rx_done & (count == FULL) & ~pop;
  assign fe_evt  = rx_framing_error & ~fe_prev;

  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // A new event in the clearing cycle wins over the clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      fe_prev       <= 1'b0;
      overflow      <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      fe_prev <= rx_framing_error;
      if (clear_status) begin
        overflow      <= ovf_evt;
        frame_err_cnt <= fe_evt ? 8'd1 : 8'd0;
      end else begin
        if (ovf_evt) overflow <= 1'b1;
        if (fe_evt && frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
      end
    end
  end

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  assign almost_full = (count >= CW'(AFULL_THRESH));

  // Tracks registered count, so it trails a count change by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      high_water <= '0;
    end else if (clear_status) begin
      high_water <= count;
    end else if (count > high_water) begin
      high_water <= count;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed plan steps plus random traffic against a queue model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 8;
  localparam int WIDTH = 9;
  localparam int AFT   = 6;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] rx_data = '0;
  logic             rx_done = 1'b0;
  logic             rx_framing_error = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    count;
  logic             overflow;
  logic [7:0]       frame_err_cnt;
  logic             clear_status = 1'b0;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  logic             almost_full;
  logic [CW-1:0]    high_water;
`endif

  always #5 clock = ~clock;

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_THRESH(AFT)) dut (
    .clock            (clock),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_done          (rx_done),
    .rx_framing_error (rx_framing_error),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .count            (count),
    .overflow         (overflow),
    .frame_err_cnt    (frame_err_cnt),
    .clear_status     (clear_status)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    ,
    .almost_full      (almost_full),
    .high_water       (high_water)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] mq[$];
  bit               m_ovf;
  int               m_fe;
  bit               m_fe_prev;
  int               m_hw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("count", 32'(count), 32'(mq.size()));
    if (mq.size() != 0) check("out_data", 32'(out_data), 32'(mq[0]));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("frame_err_cnt", 32'(frame_err_cnt), 32'(m_fe));
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    check("almost_full", 32'(almost_full), 32'(mq.size() >= AFT));
    check("high_water", 32'(high_water), 32'(m_hw));
`endif
  endtask

  // One clock: apply inputs, advance the model at the edge, compare just after it.
  task automatic step(input bit done, input logic [WIDTH-1:0] d, input bit rdy,
                      input bit fe, input bit clr, input bit rst);
    int sz;
    bit pop, push, ovf_e, fe_e;
    rx_done = done; rx_data = d; out_ready = rdy;
    rx_framing_error = fe; clear_status = clr; reset = rst;
    @(posedge clock);
    sz    = mq.size();
    pop   = (sz != 0) && rdy;
    push  = done && ((sz < DEPTH) || pop);
    ovf_e = done && (sz == DEPTH) && !pop;
    fe_e  = fe && !m_fe_prev;
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_fe = 0; m_fe_prev = 0; m_hw = 0;
    end else begin
      m_hw = clr ? sz : ((sz > m_hw) ? sz : m_hw);
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(d);
      if (clr) begin
        m_ovf = ovf_e;
        m_fe  = fe_e ? 1 : 0;
      end else begin
        if (ovf_e) m_ovf = 1;
        if (fe_e && m_fe < 255) m_fe++;
      end
      m_fe_prev = fe;
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    step(0, '0, 0, 0, 0, 1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);

    // Plan 1: single word in and out
    step(1, 9'h1A5, 0, 0, 0, 0);
    check("t1_data", 32'(out_data), 32'h1A5);
    check("t1_count", 32'(count), 32'd1);
    step(0, '0, 1, 0, 0, 0);
    check("t1_empty", 32'(out_valid), 32'd0);

    // Plan 2: overflow drops the ninth word
    for (int i = 1; i <= 9; i++) step(1, WIDTH'(i), 0, 0, 0, 0);
    check("t2_count", 32'(count), 32'd8);
    check("t2_ovf", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      check("t2_order", 32'(out_data), 32'(i));
      step(0, '0, 1, 0, 0, 0);
    end
    check("t2_drained", 32'(out_valid), 32'd0);
    step(0, '0, 0, 0, 1, 0);
    check("t2_clr", 32'(overflow), 32'd0);

    // Plan 3: push while full with a simultaneous pop
    for (int i = 1; i <= 8; i++) step(1, WIDTH'(i), 0, 0, 0, 0);
    check("t3_head", 32'(out_data), 32'h001);
    step(1, 9'h0FF, 1, 0, 0, 0);
    check("t3_count", 32'(count), 32'd8);
    check("t3_noovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("t3_last", 32'(out_data), 32'h0FF);
      step(0, '0, 1, 0, 0, 0);
    end

    // Plan 4: framing-error events
    repeat (3) step(0, '0, 0, 1, 0, 0);
    idle();
    step(0, '0, 0, 1, 0, 0);
    idle();
    check("t4_fe2", 32'(frame_err_cnt), 32'd2);
    check("t4_nopush", 32'(count), 32'd0);
    for (int i = 0; i < 300; i++) begin
      step(0, '0, 0, 1, 0, 0);
      idle();
    end
    check("t4_sat", 32'(frame_err_cnt), 32'd255);
    step(0, '0, 0, 1, 1, 0);
    check("t4_clr_evt", 32'(frame_err_cnt), 32'd1);
    idle();

    // Plan 5: reset mid-operation with a simultaneous rx_done
    for (int i = 0; i < 5; i++) step(1, WIDTH'(9'h050 + i), 0, 0, 0, 0);
    step(1, 9'h1FF, 0, 0, 0, 1);
    check("t5_count", 32'(count), 32'd0);
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_ovf", 32'(overflow), 32'd0);
    step(1, 9'h123, 0, 0, 0, 0);
    check("t5_data", 32'(out_data), 32'h123);
    step(0, '0, 1, 0, 0, 0);

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    // Plan 6: almost_full and high-water mark
    step(0, '0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, WIDTH'(9'h0A0 + i), 0, 0, 0, 0);
    idle();
    check("t6_af", 32'(almost_full), 32'd1);
    check("t6_hw", 32'(high_water), 32'd6);
    step(0, '0, 1, 0, 0, 0);
    idle();
    check("t6_af_pop", 32'(almost_full), 32'd0);
    check("t6_hw_pop", 32'(high_water), 32'd6);
    while (mq.size() != 0) step(0, '0, 1, 0, 0, 0);
`endif

    // Random traffic with varying consumer pressure
    for (int seg = 0; seg < 12; seg++) begin
      int rdy_pct;
      rdy_pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
      for (int i = 0; i < 250; i++) begin
        step($urandom_range(99) < 45,
             WIDTH'($urandom),
             $urandom_range(99) < rdy_pct,
             $urandom_range(99) < 15,
             $urandom_range(99) < 2,
             $urandom_range(999) < 4);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
